// File: rtl/sum_accumulator.sv
// Batch accumulator behind the 4-bit adder/subtractor. It sums N_SAMPLES signed samples
// into a wider register, then holds the total on a valid/ready output until it is taken.
module sum_accumulator #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int N_SAMPLES = 8,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     sum,
  input  logic                 ovf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] acc,
  output logic [3:0]           count,
  output logic                 sticky_ovf,
  output logic                 sat
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [3:0] LAST_COUNT = 4'(N_SAMPLES - 1);

  state_t               r_state, w_state_next;
  logic [ACC_WIDTH-1:0] r_acc, w_acc_next;
  logic [3:0]           r_count, w_count_next;
  logic                 r_sticky, w_sticky_next;
  logic                 r_sat, w_sat_next;
  logic                 r_in_ready, w_in_ready_next;
  logic                 r_out_valid, w_out_valid_next;

  logic [ACC_WIDTH:0]   w_sum_ext;
  logic [ACC_WIDTH:0]   w_acc_ext;
  logic [ACC_WIDTH:0]   w_sum_full;
  logic                 w_range_err;
  logic [ACC_WIDTH-1:0] w_acc_sum;
  logic                 w_accept;

  // One guard bit above the accumulator exposes overflow as a mismatch of the top two bits.
  assign w_sum_ext   = {{(ACC_WIDTH + 1 - WIDTH){sum[WIDTH-1]}}, sum};
  assign w_acc_ext   = {r_acc[ACC_WIDTH-1], r_acc};
  assign w_sum_full  = w_acc_ext + w_sum_ext;
  assign w_range_err = w_sum_full[ACC_WIDTH] ^ w_sum_full[ACC_WIDTH-1];
  assign w_accept    = in_valid & r_in_ready;

  always_comb begin
    w_acc_sum = w_sum_full[ACC_WIDTH-1:0];
    if (w_range_err && (SATURATE != 0)) begin
      w_acc_sum = w_sum_full[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_acc_next    = r_acc;
    w_count_next  = r_count;
    w_sticky_next = r_sticky;
    w_sat_next    = r_sat;
    if (clear) begin
      w_state_next  = ACCUM;
      w_acc_next    = '0;
      w_count_next  = '0;
      w_sticky_next = 1'b0;
      w_sat_next    = 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            w_acc_next    = w_acc_sum;
            w_count_next  = r_count + 4'd1;
            w_sticky_next = r_sticky | ovf;
            w_sat_next    = r_sat | w_range_err;
            if (r_count == LAST_COUNT) w_state_next = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            w_state_next  = ACCUM;
            w_acc_next    = '0;
            w_count_next  = '0;
            w_sticky_next = 1'b0;
            w_sat_next    = 1'b0;
          end
        end
        default: w_state_next = ACCUM;
      endcase
    end
    w_in_ready_next  = (w_state_next == ACCUM);
    w_out_valid_next = (w_state_next == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_count     <= '0;
      r_sticky    <= 1'b0;
      r_sat       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_acc       <= w_acc_next;
      r_count     <= w_count_next;
      r_sticky    <= w_sticky_next;
      r_sat       <= w_sat_next;
      r_in_ready  <= w_in_ready_next;
      r_out_valid <= w_out_valid_next;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign acc        = r_acc;
  assign count      = r_count;
  assign sticky_ovf = r_sticky;
  assign sat        = r_sat;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: default build plus 6-bit saturating, 6-bit wrapping
// and single-sample variants, all driven from the same input stimulus.
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] sum = 4'd0;
  logic       ovf = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, sticky_ovf, sat;
  logic [7:0] acc;
  logic [3:0] count;

  logic       s6_in_ready, s6_out_valid, s6_sticky, s6_sat;
  logic [5:0] s6_acc;
  logic [3:0] s6_count;

  logic       w6_in_ready, w6_out_valid, w6_sticky, w6_sat;
  logic [5:0] w6_acc;
  logic [3:0] w6_count;

  logic       n1_in_ready, n1_out_valid, n1_sticky, n1_sat;
  logic [7:0] n1_acc;
  logic [3:0] n1_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sum_accumulator dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready), .acc(acc),
    .count(count), .sticky_ovf(sticky_ovf), .sat(sat)
  );

  sum_accumulator #(.ACC_WIDTH(6), .SATURATE(1)) dut_s6 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(s6_in_ready),
    .sum(sum), .ovf(ovf), .out_valid(s6_out_valid), .out_ready(out_ready), .acc(s6_acc),
    .count(s6_count), .sticky_ovf(s6_sticky), .sat(s6_sat)
  );

  sum_accumulator #(.ACC_WIDTH(6), .SATURATE(0)) dut_w6 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(w6_in_ready),
    .sum(sum), .ovf(ovf), .out_valid(w6_out_valid), .out_ready(out_ready), .acc(w6_acc),
    .count(w6_count), .sticky_ovf(w6_sticky), .sat(w6_sat)
  );

  sum_accumulator #(.N_SAMPLES(1)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(n1_in_ready),
    .sum(sum), .ovf(ovf), .out_valid(n1_out_valid), .out_ready(out_ready), .acc(n1_acc),
    .count(n1_count), .sticky_ovf(n1_sticky), .sat(n1_sat)
  );

  // Offers n samples back to back; returns on the falling edge after the last accept.
  task automatic drive_samples(input logic [3:0] v, input int n, input logic o);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      sum = v;
      ovf = o;
    end
    @(negedge clk);
    in_valid = 1'b0;
    ovf = 1'b0;
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({acc, count, sticky_ovf, sat, out_valid, in_ready} !== {8'd0, 4'd0, 4'b0001}) begin
      n_fail++;
      $display("FAIL reset: acc=%0h count=%0d sticky=%b sat=%b ov=%b ir=%b required 0,0,0,0,0,1",
               acc, count, sticky_ovf, sat, out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: acc=%0h count=%0d in_ready=%b", acc, count, in_ready);
  endtask

  task automatic test_positive();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL pos_in_ready[%0d]: got %b required 1", i, in_ready);
      end
      in_valid = 1'b1;
      sum = 4'b0011;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({acc, count, out_valid, in_ready, sticky_ovf, sat} !== {8'd24, 4'd8, 4'b1000}) begin
      n_fail++;
      $display("FAIL pos_batch: acc=%0d count=%0d ov=%b ir=%b sticky=%b sat=%b required 24,8,1,0,0,0",
               acc, count, out_valid, in_ready, sticky_ovf, sat);
    end
    $display("positive: acc=%0d count=%0d out_valid=%b", acc, count, out_valid);
    release_result();
  endtask

  task automatic test_negative();
    drive_samples(4'b1000, 8, 1'b0);
    n_checks++;
    if ({acc, count, sat, out_valid} !== {8'hC0, 4'd8, 2'b01}) begin
      n_fail++;
      $display("FAIL neg_batch: acc=%0h count=%0d sat=%b ov=%b required c0,8,0,1", acc, count, sat, out_valid);
    end
    n_checks++;
    if ({s6_acc, s6_sat, w6_acc, w6_sat} !== {6'h20, 1'b1, 6'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL neg_narrow: s6=%0h/%b w6=%0h/%b required 20/1 00/1", s6_acc, s6_sat, w6_acc, w6_sat);
    end
    $display("negative: acc=%0h s6=%0h w6=%0h", acc, s6_acc, w6_acc);
    release_result();
    n_checks++;
    if ({acc, count, in_ready, out_valid} !== {8'd0, 4'd0, 2'b10}) begin
      n_fail++;
      $display("FAIL neg_release: acc=%0h count=%0d ir=%b ov=%b required 0,0,1,0", acc, count, in_ready, out_valid);
    end
  endtask

  task automatic test_saturate();
    drive_samples(4'b0111, 8, 1'b0);
    n_checks++;
    if ({acc, sat} !== {8'd56, 1'b0}) begin
      n_fail++;
      $display("FAIL sat_wide: acc=%0d sat=%b required 56,0", acc, sat);
    end
    n_checks++;
    if ({s6_acc, s6_sat, s6_out_valid} !== {6'h1F, 2'b11}) begin
      n_fail++;
      $display("FAIL sat_clamp: acc=%0h sat=%b ov=%b required 1f,1,1", s6_acc, s6_sat, s6_out_valid);
    end
    n_checks++;
    if ({w6_acc, w6_sat, w6_out_valid} !== {6'h38, 2'b11}) begin
      n_fail++;
      $display("FAIL sat_wrap: acc=%0h sat=%b ov=%b required 38,1,1", w6_acc, w6_sat, w6_out_valid);
    end
    $display("saturate: acc=%0d s6=%0h w6=%0h", acc, s6_acc, w6_acc);
    release_result();
  endtask

  task automatic test_sticky_hold();
    drive_samples(4'b0001, 2, 1'b0);
    drive_samples(4'b1111, 1, 1'b1);
    drive_samples(4'b0000, 5, 1'b0);
    n_checks++;
    if ({acc, count, sticky_ovf, sat, out_valid} !== {8'd1, 4'd8, 3'b101}) begin
      n_fail++;
      $display("FAIL sticky_batch: acc=%0d count=%0d sticky=%b sat=%b ov=%b required 1,8,1,0,1",
               acc, count, sticky_ovf, sat, out_valid);
    end
    in_valid = 1'b1;
    sum = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({acc, count, sticky_ovf, out_valid, in_ready} !== {8'd1, 4'd8, 3'b110}) begin
        n_fail++;
        $display("FAIL hold[%0d]: acc=%0d count=%0d sticky=%b ov=%b ir=%b required 1,8,1,1,0",
                 i, acc, count, sticky_ovf, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    $display("sticky_hold: acc=%0d sticky=%b", acc, sticky_ovf);
    release_result();
  endtask

  task automatic test_clear();
    drive_samples(4'b0010, 5, 1'b0);
    n_checks++;
    if ({acc, count} !== {8'd10, 4'd5}) begin
      n_fail++;
      $display("FAIL clear_pre: acc=%0d count=%0d required 10,5", acc, count);
    end
    @(negedge clk);
    clear = 1'b1;
    in_valid = 1'b1;
    sum = 4'b0010;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if ({acc, count, in_ready, out_valid} !== {8'd0, 4'd0, 2'b10}) begin
      n_fail++;
      $display("FAIL clear: acc=%0d count=%0d ir=%b ov=%b required 0,0,1,0", acc, count, in_ready, out_valid);
    end
    drive_samples(4'b0001, 8, 1'b0);
    n_checks++;
    if ({acc, count, out_valid} !== {8'd8, 4'd8, 1'b1}) begin
      n_fail++;
      $display("FAIL clear_post: acc=%0d count=%0d ov=%b required 8,8,1", acc, count, out_valid);
    end
    $display("clear: acc=%0d count=%0d", acc, count);
    release_result();
  endtask

  task automatic test_async_reset();
    drive_samples(4'b0001, 8, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready, acc, count} !== {2'b01, 8'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL async_reset: ov=%b ir=%b acc=%0d count=%0d required 0,1,0,0", out_valid, in_ready, acc, count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_samples(4'b0001, 8, 1'b0);
    n_checks++;
    if ({acc, count, out_valid} !== {8'd8, 4'd8, 1'b1}) begin
      n_fail++;
      $display("FAIL async_post: acc=%0d count=%0d ov=%b required 8,8,1", acc, count, out_valid);
    end
    $display("async_reset: acc=%0d", acc);
    release_result();
  endtask

  task automatic test_single_sample();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_samples(4'b0101, 1, 1'b0);
    n_checks++;
    if ({n1_acc, n1_count, n1_out_valid, n1_in_ready} !== {8'd5, 4'd1, 2'b10}) begin
      n_fail++;
      $display("FAIL n1_batch: acc=%0d count=%0d ov=%b ir=%b required 5,1,1,0", n1_acc, n1_count, n1_out_valid, n1_in_ready);
    end
    release_result();
    n_checks++;
    if ({n1_acc, n1_count, n1_out_valid, n1_in_ready} !== {8'd0, 4'd0, 2'b01}) begin
      n_fail++;
      $display("FAIL n1_release: acc=%0d count=%0d ov=%b ir=%b required 0,0,0,1", n1_acc, n1_count, n1_out_valid, n1_in_ready);
    end
    n_checks++;
    if ({acc, count, out_valid, in_ready} !== {8'd5, 4'd1, 2'b01}) begin
      n_fail++;
      $display("FAIL accum_ignores_ready: acc=%0d count=%0d ov=%b ir=%b required 5,1,0,1", acc, count, out_valid, in_ready);
    end
    $display("single_sample: n1_acc=%0d main_count=%0d", n1_acc, count);
  endtask

  initial begin
    test_reset();
    test_positive();
    test_negative();
    test_saturate();
    test_sticky_hold();
    test_clear();
    test_async_reset();
    test_single_sample();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream stage of the 4-bit ripple adder/subtractor.
- Consumes the adder's sum bits (S3..S0, two's complement) and its overflow flag V, one sample per handshake.
- Accumulates a fixed number of samples into a wider signed register, with optional saturation, a sticky overflow flag and a saturation flag.
- Presents the completed total on a valid/ready output, then re-arms for the next batch.

Parameters:
- WIDTH, 4, width of incoming adder sum; sign bit is MSB (S3).
- ACC_WIDTH, 8, width of signed accumulator; must be greater than WIDTH.
- N_SAMPLES, 8, samples per batch; range 1..15.
- SATURATE, 1, 1 = clamp on accumulator overflow, 0 = two's-complement wrap.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous batch abort; highest priority after reset.
- in_valid  input  1  sample present.
- in_ready  output  1  block can accept a sample.
- sum  input  WIDTH  adder sum; bit0 = S0.
- ovf  input  1  adder overflow V, qualified by in_valid.
- out_valid  output  1  batch result available.
- out_ready  input  1  consumer takes the result.
- acc  output  ACC_WIDTH  signed batch total.
- count  output  4  samples accepted in the current batch.
- sticky_ovf  output  1  at least one accepted sample had ovf=1.
- sat  output  1  accumulator clamped or wrapped at least once this batch.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, asynchronous):
  - state=ACCUM.
  - acc=0, count=0, sticky_ovf=0, sat=0, out_valid=0, in_ready=1.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1, acc/count/flags frozen.
- Accept rule: a sample is accepted on a rising edge with in_valid=1 and in_ready=1.
- On accept:
  - next = acc + sign_extend(sum) to ACC_WIDTH+1 bits.
  - count increments by 1.
  - sticky_ovf is ORed with ovf.
- Saturation, SATURATE=1:
  - If next exceeds 2^(ACC_WIDTH-1)-1, acc = max positive.
  - If next is below -2^(ACC_WIDTH-1), acc = min negative.
  - Either clamp sets sat=1.
- Saturation, SATURATE=0: acc = next truncated to ACC_WIDTH bits; sat=1 whenever the truncation changes the signed value.
- A sample with ovf=1 is still added as its raw 4-bit value. Only sticky_ovf records it; no correction is applied.
- Batch completion: the accept that makes count reach N_SAMPLES moves the state to HOLD on that same edge. out_valid is visible the cycle after the last accept (latency 1).
- HOLD exit: an edge with out_ready=1 returns the state to ACCUM with acc=0, count=0, sticky_ovf=0, sat=0.
  - in_ready is high again the next cycle.
  - No sample is accepted in the HOLD-exit cycle, because in_ready=0 then.
- out_ready while in ACCUM is ignored.
- in_valid while in HOLD is ignored; the upstream must hold its data.
- clear=1 on an edge, in any state:
  - Same result as reset, but synchronous.
  - A pending HOLD result is discarded.
  - A sample offered in the same cycle is not accepted.
- rst_n asserted mid-batch or in HOLD: immediate return to reset values. No partial result is emitted.
- N_SAMPLES=1: every accept goes straight to HOLD.

Test Plan:
- Reset, then 8 samples of sum=4'b0011 (+3) with in_valid held high -> in_ready high 8 cycles; acc=24 and count=8; out_valid=1 on the next cycle; sticky_ovf=0, sat=0.
- 8 samples of sum=4'b1000 (-8) -> acc=-64 (8'hC0), sat=0. Then out_ready=1 -> acc=0, count=0, in_ready=1 the following cycle.
- ACC_WIDTH=6, SATURATE=1, 8 samples of +7 -> acc=31 (6'h1F), sat=1. With SATURATE=0 -> acc=56 mod 64, i.e. -8 (6'h38), sat=1.
- Samples +1, +1, -1 with ovf=1 on the third, then +0 five times -> acc=1, sticky_ovf=1. out_valid held across 3 cycles of out_ready=0 with in_valid=1 -> acc, count and flags unchanged, no sample accepted.
- After 5 samples of +2, clear=1 together with in_valid=1 -> next cycle acc=0 and count=0. A further 8 samples of +1 give acc=8.
- rst_n pulsed low asynchronously while in HOLD (between clock edges) -> out_valid drops immediately, acc=0; a full batch of +1 afterwards yields acc=8.
